count_lockstep_checker: RTL and testbench

Downstream monitor for the 4-bit free-running counters in the counter stage. It samples two count streams, a reference count and a count under test, on every rising `clk`. It flags any cycle where they disagree and keeps sticky fault status and a saturating error count. It also reports wrap-around of the reference count, so the lockstep check that the bench performs in software becomes a synthesizable block.

---
 rtl/count_lockstep_checker_if.sv | 28 ++
 rtl/count_lockstep_checker.sv | 122 ++++++++++++
 tb/tb_count_lockstep_checker.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/count_lockstep_checker_if.sv
// Signal bundle between a count-stream source and count_lockstep_checker.
// master drives the arm/clear controls and both counts; slave returns lockstep status.
interface count_lockstep_checker_if #(
   parameter int WIDTH     = 4,
   parameter int ERR_CNT_W = 8
);
   logic                 en;
   logic                 clr;
   logic [WIDTH-1:0]     cnt_a;
   logic [WIDTH-1:0]     cnt_b;
   logic                 armed;
   logic                 mismatch;
   logic                 err_sticky;
   logic [ERR_CNT_W-1:0] err_count;
   logic [WIDTH-1:0]     first_a;
   logic [WIDTH-1:0]     first_b;
   logic                 wrap;

   modport master (
      output en, clr, cnt_a, cnt_b,
      input  armed, mismatch, err_sticky, err_count, first_a, first_b, wrap
   );

   modport slave (
      input  en, clr, cnt_a, cnt_b,
      output armed, mismatch, err_sticky, err_count, first_a, first_b, wrap
   );
endinterface

// File: rtl/count_lockstep_checker.sv
// Lockstep monitor for two count streams; status lags the input sample by one edge, no backpressure.
// Optional step check (a_q == a_p + 1) is compiled in with `define LOCKSTEP_STEP_CHECK_EN.
module count_lockstep_checker #(
   parameter int WIDTH     = 4,
   parameter int GRACE     = 2,
   parameter int ERR_CNT_W = 8
) (
   input  logic                   clk,
   input  logic                   rstn,
   count_lockstep_checker_if.slave bus
);
   typedef enum logic [1:0] {S_IDLE, S_GRACE, S_CHECK, S_FAULT} state_t;

   localparam logic [3:0] GRACE_LD = (GRACE > 0) ? 4'(GRACE - 1) : 4'd0;

   state_t               state, state_nxt;
   logic [3:0]           gcnt, gcnt_nxt;
   logic                 grace_done;
   logic [WIDTH-1:0]     a_q, b_q, a_p;
   logic                 cmp_act, fault;
   logic                 armed_r, mismatch_r, sticky_r, wrap_r;
   logic [ERR_CNT_W-1:0] err_cnt_r;
   logic [WIDTH-1:0]     first_a_r, first_b_r;

   assign cmp_act = bus.en && (state == S_CHECK || state == S_FAULT);

`ifdef LOCKSTEP_STEP_CHECK_EN
   // a_p is stale on the first compare after arming, so its step is not judged
   logic first_cmp;
   logic step_err;
   assign step_err = !first_cmp && (a_q != a_p + WIDTH'(1));
   assign fault    = cmp_act && ((a_q != b_q) || step_err);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) first_cmp <= 1'b0;
      else       first_cmp <= (state == S_IDLE || state == S_GRACE) && (state_nxt == S_CHECK);
   end
`else
   assign fault = cmp_act && (a_q != b_q);
`endif

   always_comb begin
      state_nxt = state;
      gcnt_nxt  = gcnt;
      if (!bus.en) begin
         state_nxt = S_IDLE;
      end else begin
         unique case (state)
            S_IDLE: begin
               if (GRACE > 0) begin
                  state_nxt = S_GRACE;
                  gcnt_nxt  = GRACE_LD;
               end else begin
                  state_nxt = S_CHECK;
               end
            end
            S_GRACE: begin
               // leave one edge after the counter has been observed at zero
               if (grace_done)       state_nxt = S_CHECK;
               else if (gcnt != 4'd0) gcnt_nxt = gcnt - 4'd1;
            end
            S_CHECK: if (!bus.clr && fault) state_nxt = S_FAULT;
            S_FAULT: if (bus.clr)           state_nxt = S_CHECK;
            default: state_nxt = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state      <= S_IDLE;
         gcnt       <= 4'd0;
         grace_done <= 1'b0;
         a_q        <= '0;
         b_q        <= '0;
         a_p        <= '0;
         armed_r    <= 1'b0;
         mismatch_r <= 1'b0;
         wrap_r     <= 1'b0;
      end else begin
         state      <= state_nxt;
         gcnt       <= gcnt_nxt;
         grace_done <= bus.en && (state == S_GRACE) && (gcnt == 4'd0);
         a_q        <= bus.cnt_a;
         b_q        <= bus.cnt_b;
         a_p        <= a_q;
         armed_r    <= (state_nxt == S_CHECK) || (state_nxt == S_FAULT);
         mismatch_r <= fault;
         wrap_r     <= (state != S_IDLE) && (a_p == {WIDTH{1'b1}}) && (a_q == '0);
      end
   end

   // clr wins over a same-cycle fault; the mismatch pulse above is unaffected
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         sticky_r  <= 1'b0;
         err_cnt_r <= '0;
         first_a_r <= '0;
         first_b_r <= '0;
      end else if (bus.clr) begin
         sticky_r  <= 1'b0;
         err_cnt_r <= '0;
         first_a_r <= '0;
         first_b_r <= '0;
      end else if (fault) begin
         sticky_r <= 1'b1;
         if (err_cnt_r != {ERR_CNT_W{1'b1}}) err_cnt_r <= err_cnt_r + ERR_CNT_W'(1);
         if (state == S_CHECK) begin
            first_a_r <= a_q;
            first_b_r <= b_q;
         end
      end
   end

   assign bus.armed      = armed_r;
   assign bus.mismatch   = mismatch_r;
   assign bus.err_sticky = sticky_r;
   assign bus.err_count  = err_cnt_r;
   assign bus.first_a    = first_a_r;
   assign bus.first_b    = first_b_r;
   assign bus.wrap       = wrap_r;
endmodule

// File: tb/tb_count_lockstep_checker.sv
// Scoreboard bench for count_lockstep_checker: per-cycle expected status is queued by the
// stimulus and popped by a monitor just after each rising edge.
module tb_count_lockstep_checker;
   typedef struct {
      int armed;
      int mis;
      int sticky;
      int cnt;
      int fa;
      int fb;
      int wrap;
   } exp_t;

`ifdef LOCKSTEP_STEP_CHECK_EN
   localparam bit STEP = 1'b1;
`else
   localparam bit STEP = 1'b0;
`endif

   logic clk;
   logic rstn;
   int   n_chk  = 0;
   int   n_pass = 0;
   exp_t exp_q[$];

   count_lockstep_checker_if #(.WIDTH(4), .ERR_CNT_W(8)) bus ();

   count_lockstep_checker #(.WIDTH(4), .GRACE(2), .ERR_CNT_W(8)) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus.slave)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input int got, input int want);
      n_chk++;
      if (got == want) n_pass++;
      else $display("FAIL %s @%0t: got %0d, expected %0d", name, $time, got, want);
   endtask

   function automatic exp_t mk(input int armed, mis, sticky, cnt, fa, fb, wrap);
      exp_t e;
      e.armed = armed; e.mis = mis; e.sticky = sticky; e.cnt = cnt;
      e.fa = fa; e.fb = fb; e.wrap = wrap;
      return e;
   endfunction

   // drive inputs for the coming edge and queue the status expected right after it
   task automatic cyc(input int en, input int clr, input int a, input int b, input exp_t e);
      @(negedge clk);
      bus.en    = en[0];
      bus.clr   = clr[0];
      bus.cnt_a = 4'(a);
      bus.cnt_b = 4'(b);
      exp_q.push_back(e);
   endtask

   // counting 0..15 from step 0: wrap follows the edge after the 0 sample
   function automatic int wrapx(input int k);
      return (k >= 2 && ((k - 1) % 16) == 0) ? 1 : 0;
   endfunction

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("armed",      int'(bus.armed),      e.armed);
            chk("mismatch",   int'(bus.mismatch),   e.mis);
            chk("err_sticky", int'(bus.err_sticky), e.sticky);
            chk("err_count",  int'(bus.err_count),  e.cnt);
            chk("first_a",    int'(bus.first_a),    e.fa);
            chk("first_b",    int'(bus.first_b),    e.fb);
            chk("wrap",       int'(bus.wrap),       e.wrap);
         end
      end
   end

   initial begin : watchdog
      #200us;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "bench timeout");
   end

   initial begin : stim
      int v;
      int s;
      rstn      = 1'b0;
      bus.en    = 1'b0;
      bus.clr   = 1'b0;
      bus.cnt_a = '0;
      bus.cnt_b = '0;

      for (int k = 0; k < 3; k++) cyc(0, 0, 0, 0, mk(0, 0, 0, 0, 0, 0, 0));
      rstn = 1'b1;

      // arm, equal counting with wraps, then a single 4-vs-5 mismatch at step 52
      for (int k = 0; k < 59; k++) begin
         v = k % 16;
         cyc(1, 0, v, (k == 52) ? 5 : v,
             mk(k >= 3 ? 1 : 0, k == 53 ? 1 : 0, k >= 53 ? 1 : 0, k >= 53 ? 1 : 0,
                k >= 53 ? 4 : 0, k >= 53 ? 5 : 0, wrapx(k)));
      end

      // persistent mismatch for 300 cycles; count saturates, first_* stays from the FAULT entry
      for (int k = 59; k < 359; k++) begin
         v = k % 16;
         cyc(1, 0, v, (v + 8) % 16,
             mk(1, k >= 60 ? 1 : 0, 1, (k == 59) ? 1 : ((k - 58 > 255) ? 255 : k - 58),
                4, 5, wrapx(k)));
      end

      // clr during a mismatched compare, then a fresh capture proves the state went back to CHECK
      cyc(1, 1,  7,  7, mk(1, 1, 0, 0, 0, 0, 0));
      cyc(1, 0,  8,  8, mk(1, 0, 0, 0, 0, 0, 0));
      cyc(1, 0,  9,  2, mk(1, 0, 0, 0, 0, 0, 0));
      cyc(1, 0, 10, 10, mk(1, 1, 1, 1, 9, 2, 0));
      cyc(1, 0, 11, 11, mk(1, 0, 1, 1, 9, 2, 0));
      // disarm keeps status; disarm with clr wipes it
      cyc(0, 0, 12, 12, mk(0, 0, 1, 1, 9, 2, 0));
      cyc(0, 1, 13, 13, mk(0, 0, 0, 0, 0, 0, 0));

      // re-arm, both counts jump 3 -> 7 after CHECK is reached
      s = STEP ? 1 : 0;
      for (int k = 0; k < 10; k++) begin
         v = (k <= 3) ? k : k + 3;
         cyc(1, 0, v, v,
             mk(k >= 3 ? 1 : 0, (s == 1 && k == 5) ? 1 : 0, (s == 1 && k >= 5) ? 1 : 0,
                (s == 1 && k >= 5) ? 1 : 0, (s == 1 && k >= 5) ? 7 : 0,
                (s == 1 && k >= 5) ? 7 : 0, 0));
      end

      // asynchronous reset in the middle of a cycle while armed
      @(posedge clk);
      #3;
      rstn = 1'b0;
      #1;
      chk("async_rst_armed",  int'(bus.armed),      0);
      chk("async_rst_sticky", int'(bus.err_sticky), 0);
      cyc(1, 0, 0, 0, mk(0, 0, 0, 0, 0, 0, 0));
      cyc(1, 0, 0, 0, mk(0, 0, 0, 0, 0, 0, 0));

      @(posedge clk);
      #2;
      chk("queue_drained", exp_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
